// File: rtl/reset_sequencer.sv
// Staged fabric reset release gated on synchronised POR, init-done and PLL lock.
// Optional lock-loss counter is built only when RESET_SEQ_LOCK_LOSS_CNT_EN is defined.
module reset_sequencer #(
  parameter int NUM_LOCKS   = 2,
  parameter int NUM_STAGES  = 3,
  parameter int STAGE_DELAY = 16,
  parameter int LOCK_FILTER = 8
) (
  input  logic                  CLK,
  input  logic                  EXT_RST_N,
  input  logic [NUM_LOCKS-1:0]  PLL_LOCK,
  input  logic                  INIT_DONE,
  input  logic                  FPGA_POR_N,
  output logic [NUM_STAGES-1:0] FABRIC_RESET_N,
  output logic                  PLL_POWERDOWN_B,
  output logic                  SEQ_DONE,
  output logic [7:0]            LOCK_LOSS_CNT
);

  localparam int FILT_W = $clog2(LOCK_FILTER + 1);
  localparam int DLY_W  = $clog2(STAGE_DELAY + 1);
  localparam int STG_W  = $clog2(NUM_STAGES + 1);
  localparam int SYN_W  = NUM_LOCKS + 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LOCK = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  state_t                  state_r, state_nxt_s;
  logic [SYN_W-1:0]        sync1_r, sync2_r;
  logic [FILT_W-1:0]       filt_r, filt_nxt_s;
  logic [DLY_W-1:0]        dly_r, dly_nxt_s;
  logic [STG_W-1:0]        stg_r, stg_nxt_s;
  logic [NUM_STAGES-1:0]   fab_r, fab_nxt_s;
  logic                    done_r, done_nxt_s;
  logic                    pd_r;
  logic [NUM_LOCKS-1:0]    lock_s;
  logic                    init_s, por_s, all_lock_s;

  // Thermometer code with the n lowest bits set.
  function automatic logic [NUM_STAGES-1:0] therm(input logic [STG_W-1:0] n);
    logic [NUM_STAGES-1:0] t;
    for (int i = 0; i < NUM_STAGES; i++) begin
      t[i] = (STG_W'(i) < n);
    end
    return t;
  endfunction

  // Two-flop synchronisers for every asynchronous control input.
  always_ff @(posedge CLK or negedge EXT_RST_N) begin
    if (!EXT_RST_N) begin
      sync1_r <= {SYN_W{1'b0}};
      sync2_r <= {SYN_W{1'b0}};
    end else begin
      sync1_r <= {FPGA_POR_N, INIT_DONE, PLL_LOCK};
      sync2_r <= sync1_r;
    end
  end

  assign lock_s     = sync2_r[NUM_LOCKS-1:0];
  assign init_s     = sync2_r[NUM_LOCKS];
  assign por_s      = sync2_r[NUM_LOCKS+1];
  assign all_lock_s = &lock_s;

  // Next-state and next-output logic; loss of POR/init overrides everything.
  always_comb begin
    state_nxt_s = state_r;
    filt_nxt_s  = filt_r;
    dly_nxt_s   = dly_r;
    stg_nxt_s   = stg_r;
    fab_nxt_s   = fab_r;
    done_nxt_s  = done_r;
    if (!por_s || !init_s) begin
      state_nxt_s = IDLE;
      filt_nxt_s  = {FILT_W{1'b0}};
      dly_nxt_s   = {DLY_W{1'b0}};
      stg_nxt_s   = {STG_W{1'b0}};
      fab_nxt_s   = {NUM_STAGES{1'b0}};
      done_nxt_s  = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt_s = WAIT_LOCK;
          filt_nxt_s  = {FILT_W{1'b0}};
        end
        WAIT_LOCK: begin
          if (!all_lock_s) begin
            filt_nxt_s = {FILT_W{1'b0}};
          end else if (filt_r == FILT_W'(LOCK_FILTER - 1)) begin
            state_nxt_s  = RELEASE;
            filt_nxt_s   = {FILT_W{1'b0}};
            dly_nxt_s    = {DLY_W{1'b0}};
            stg_nxt_s    = {STG_W{1'b0}};
            fab_nxt_s    = {NUM_STAGES{1'b0}};
            fab_nxt_s[0] = 1'b1;
            done_nxt_s   = (NUM_STAGES == 1) ? 1'b1 : 1'b0;
          end else begin
            filt_nxt_s = filt_r + FILT_W'(1);
          end
        end
        RELEASE: begin
          if (!all_lock_s) begin
            state_nxt_s = FAULT;
            dly_nxt_s   = {DLY_W{1'b0}};
            stg_nxt_s   = {STG_W{1'b0}};
            fab_nxt_s   = {NUM_STAGES{1'b0}};
            done_nxt_s  = 1'b0;
          end else if (stg_r == STG_W'(NUM_STAGES - 1)) begin
            // Only reachable with a single stage: it was released on entry.
            state_nxt_s = RUN;
            done_nxt_s  = 1'b1;
          end else if (dly_r == DLY_W'(STAGE_DELAY - 1)) begin
            dly_nxt_s = {DLY_W{1'b0}};
            stg_nxt_s = stg_r + STG_W'(1);
            fab_nxt_s = therm(stg_r + STG_W'(2));
            if (stg_r + STG_W'(1) == STG_W'(NUM_STAGES - 1)) begin
              state_nxt_s = RUN;
              done_nxt_s  = 1'b1;
            end else begin
              done_nxt_s  = 1'b0;
            end
          end else begin
            dly_nxt_s = dly_r + DLY_W'(1);
          end
        end
        RUN: begin
          if (!all_lock_s) begin
            state_nxt_s = FAULT;
            stg_nxt_s   = {STG_W{1'b0}};
            fab_nxt_s   = {NUM_STAGES{1'b0}};
            done_nxt_s  = 1'b0;
          end else begin
            state_nxt_s = RUN;
          end
        end
        FAULT: begin
          state_nxt_s = WAIT_LOCK;
          filt_nxt_s  = {FILT_W{1'b0}};
        end
        default: begin
          state_nxt_s = IDLE;
          fab_nxt_s   = {NUM_STAGES{1'b0}};
          done_nxt_s  = 1'b0;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK or negedge EXT_RST_N) begin
    if (!EXT_RST_N) begin
      state_r <= IDLE;
      filt_r  <= {FILT_W{1'b0}};
      dly_r   <= {DLY_W{1'b0}};
      stg_r   <= {STG_W{1'b0}};
      fab_r   <= {NUM_STAGES{1'b0}};
      done_r  <= 1'b0;
      pd_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      filt_r  <= filt_nxt_s;
      dly_r   <= dly_nxt_s;
      stg_r   <= stg_nxt_s;
      fab_r   <= fab_nxt_s;
      done_r  <= done_nxt_s;
      pd_r    <= (state_nxt_s != IDLE);
    end
  end

  assign FABRIC_RESET_N  = fab_r;
  assign SEQ_DONE        = done_r;
  assign PLL_POWERDOWN_B = pd_r;

`ifdef RESET_SEQ_LOCK_LOSS_CNT_EN
  logic [7:0] llc_r;

  // Saturating count of FAULT entries; survives IDLE, cleared only by EXT_RST_N.
  always_ff @(posedge CLK or negedge EXT_RST_N) begin
    if (!EXT_RST_N) begin
      llc_r <= 8'd0;
    end else if ((state_nxt_s == FAULT) && (state_r != FAULT) && (llc_r != 8'd255)) begin
      llc_r <= llc_r + 8'd1;
    end else begin
      llc_r <= llc_r;
    end
  end

  assign LOCK_LOSS_CNT = llc_r;
`else
  assign LOCK_LOSS_CNT = 8'd0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed vector table, hand sequences and random
// stimulus, all compared against an event-level reference model.
module tb_reset_sequencer;
  localparam int NS = 3;
  localparam int SD = 16;
  localparam int LF = 8;
`ifdef RESET_SEQ_LOCK_LOSS_CNT_EN
  localparam bit LLC_EN = 1'b1;
`else
  localparam bit LLC_EN = 1'b0;
`endif
  localparam logic [7:0] LLC_ONE = LLC_EN ? 8'd1 : 8'd0;
  localparam logic [7:0] LLC_SAT = LLC_EN ? 8'd255 : 8'd0;

  logic       CLK = 1'b0;
  logic       EXT_RST_N = 1'b0;
  logic [1:0] PLL_LOCK = 2'b11;
  logic       INIT_DONE = 1'b1;
  logic       FPGA_POR_N = 1'b1;
  logic [2:0] FABRIC_RESET_N;
  logic       PLL_POWERDOWN_B;
  logic       SEQ_DONE;
  logic [7:0] LOCK_LOSS_CNT;

  int total = 0;
  int bad = 0;

  reset_sequencer #(.NUM_LOCKS(2), .NUM_STAGES(NS), .STAGE_DELAY(SD), .LOCK_FILTER(LF)) dut (
    .CLK(CLK), .EXT_RST_N(EXT_RST_N), .PLL_LOCK(PLL_LOCK), .INIT_DONE(INIT_DONE),
    .FPGA_POR_N(FPGA_POR_N), .FABRIC_RESET_N(FABRIC_RESET_N),
    .PLL_POWERDOWN_B(PLL_POWERDOWN_B), .SEQ_DONE(SEQ_DONE), .LOCK_LOSS_CNT(LOCK_LOSS_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: inputs reach the sequencer two clocks late; the release
  // pattern is a function of the time elapsed since the first stage came out.
  logic [3:0] h1 = 4'd0, h2 = 4'd0, seen;
  bit m_up = 1'b0, m_fault = 1'b0;
  int m_run = 0, m_rel = -1, m_cyc = 0, m_llc = 0;

  initial forever begin
    @(posedge CLK or negedge EXT_RST_N);
    if (!EXT_RST_N) begin
      h1 = 4'd0; h2 = 4'd0; m_up = 1'b0; m_fault = 1'b0;
      m_run = 0; m_rel = -1; m_llc = 0;
    end else begin
      m_cyc++;
      seen = h2;
      h2 = h1;
      h1 = {FPGA_POR_N, INIT_DONE, PLL_LOCK};
      if (!(seen[3] && seen[2])) begin
        m_up = 1'b0; m_fault = 1'b0; m_run = 0; m_rel = -1;
      end else if (!m_up) begin
        m_up = 1'b1; m_run = 0;
      end else if (m_fault) begin
        m_fault = 1'b0; m_run = 0;
      end else if (m_rel >= 0) begin
        if (seen[1:0] != 2'b11) begin
          m_rel = -1; m_fault = 1'b1;
          if (m_llc < 255) m_llc++;
        end
      end else if (seen[1:0] == 2'b11) begin
        m_run++;
        if (m_run == LF) m_rel = m_cyc;
      end else begin
        m_run = 0;
      end
    end
  end

  function automatic logic [2:0] exp_fab();
    int n;
    if (m_rel < 0) return 3'b000;
    n = (m_cyc - m_rel) / SD + 1;
    if (n > NS) n = NS;
    return 3'((1 << n) - 1);
  endfunction

  function automatic logic exp_done();
    return (m_rel >= 0) && ((m_cyc - m_rel) >= (NS - 1) * SD);
  endfunction

  initial forever begin
    @(negedge CLK);
    check("model_fab", FABRIC_RESET_N, exp_fab());
    check("model_pd", PLL_POWERDOWN_B, m_up);
    check("model_done", SEQ_DONE, exp_done());
    check("model_llc", LOCK_LOSS_CNT, LLC_EN ? m_llc : 0);
  end

  typedef struct {
    bit         rst;
    bit         por;
    bit         init;
    logic [1:0] lock;
    int         edges;
    logic [2:0] fab;
    bit         pd;
    bit         done;
    logic [7:0] llc;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int n;
    int r;
    int len;
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 2'b11,  3, 3'b000, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 2'b11,  2, 3'b000, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 2'b11,  1, 3'b000, 1'b1, 1'b0, 8'd0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 2'b11,  7, 3'b000, 1'b1, 1'b0, 8'd0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 2'b11,  1, 3'b001, 1'b1, 1'b0, 8'd0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 2'b11, 15, 3'b001, 1'b1, 1'b0, 8'd0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 2'b11,  1, 3'b011, 1'b1, 1'b0, 8'd0};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 2'b11, 16, 3'b111, 1'b1, 1'b1, 8'd0};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 2'b10,  2, 3'b111, 1'b1, 1'b1, 8'd0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 2'b10,  1, 3'b000, 1'b1, 1'b0, LLC_ONE};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 2'b11,  9, 3'b000, 1'b1, 1'b0, LLC_ONE};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 2'b11,  1, 3'b001, 1'b1, 1'b0, LLC_ONE};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 2'b11, 16, 3'b011, 1'b1, 1'b0, LLC_ONE};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 2'b11,  2, 3'b011, 1'b1, 1'b0, LLC_ONE};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 2'b11,  1, 3'b000, 1'b0, 1'b0, LLC_ONE};

    @(negedge CLK);
    for (int i = 0; i < 15; i++) begin
      #2;
      EXT_RST_N  = vecs[i].rst;
      FPGA_POR_N = vecs[i].por;
      INIT_DONE  = vecs[i].init;
      PLL_LOCK   = vecs[i].lock;
      repeat (vecs[i].edges) @(posedge CLK);
      @(negedge CLK);
      check($sformatf("vec%0d_fab", i), FABRIC_RESET_N, vecs[i].fab);
      check($sformatf("vec%0d_pd", i), PLL_POWERDOWN_B, vecs[i].pd);
      check($sformatf("vec%0d_done", i), SEQ_DONE, vecs[i].done);
      check($sformatf("vec%0d_llc", i), LOCK_LOSS_CNT, vecs[i].llc);
    end

    // Reset asserted in RELEASE clears everything before the next edge.
    #2 INIT_DONE = 1'b1;
    repeat (11) @(posedge CLK);
    @(negedge CLK);
    check("rel_entry_fab", FABRIC_RESET_N, 3'b001);
    #2 EXT_RST_N = 1'b0;
    #1;
    check("async_fab", FABRIC_RESET_N, 3'b000);
    check("async_pd", PLL_POWERDOWN_B, 1'b0);
    check("async_done", SEQ_DONE, 1'b0);
    check("async_llc", LOCK_LOSS_CNT, 8'd0);
    @(negedge CLK);
    @(negedge CLK);
    #2 EXT_RST_N = 1'b1;

    // Lock glitch every fifth cycle keeps the filter from ever completing.
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      #2 PLL_LOCK = (i % 5 == 4) ? 2'b01 : 2'b11;
    end
    @(negedge CLK);
    check("no_release", FABRIC_RESET_N, 3'b000);
    #2 PLL_LOCK = 2'b11;
    n = 0;
    while (n < 30 && FABRIC_RESET_N[0] !== 1'b1) begin
      @(posedge CLK);
      #1 n++;
    end
    check("filter_latency", n, 10);

    // Random stimulus segments, checked cycle by cycle against the model.
    for (int s = 0; s < 60; s++) begin
      r = $urandom_range(0, 9);
      len = $urandom_range(1, 50);
      for (int c = 0; c < len; c++) begin
        @(negedge CLK);
        #2;
        EXT_RST_N = ($urandom_range(0, 199) != 0);
        case (r)
          6, 7: begin
            FPGA_POR_N = 1'b1; INIT_DONE = 1'b1; PLL_LOCK = 2'($urandom_range(0, 3));
          end
          8: begin
            FPGA_POR_N = 1'b1; INIT_DONE = 1'($urandom_range(0, 1)); PLL_LOCK = 2'b11;
          end
          9: begin
            FPGA_POR_N = 1'($urandom_range(0, 1)); INIT_DONE = 1'b1; PLL_LOCK = 2'b11;
          end
          default: begin
            FPGA_POR_N = 1'b1; INIT_DONE = 1'b1; PLL_LOCK = 2'b11;
          end
        endcase
      end
    end

    // Repeated lock losses from RUN drive the counter into saturation.
    @(negedge CLK);
    #2;
    EXT_RST_N = 1'b1; FPGA_POR_N = 1'b1; INIT_DONE = 1'b1;
    repeat (300) begin
      PLL_LOCK = 2'b11;
      repeat (50) @(negedge CLK);
      #2 PLL_LOCK = 2'b10;
      repeat (4) @(negedge CLK);
      #2;
    end
    PLL_LOCK = 2'b11;
    repeat (2) @(negedge CLK);
    check("llc_sat", LOCK_LOSS_CNT, LLC_SAT);

    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
